// File: rtl/pattern_pkg.sv
// Shared FSM encoding and default widths for the pattern transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pattern_pkg;

    localparam int PAT_W_DEF = 5;
    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } pat_state_t;

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load shift register presenting its MSB; zeros shift in from the LSB.
// Latency: load or shift is visible on msb one cycle later.
// Backpressure: the caller holds shift_en low to stall; contents stay put.
module pattern_shift_reg #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [PAT_W-1:0] load_dat,
    output logic             msb
);

    logic [PAT_W-1:0] sr;

    // Load wins over shift so a back-to-back reload never loses the new MSB.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_dat;
        end else if (shift_en) begin
            sr <= {sr[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = sr[PAT_W-1];

endmodule

// File: rtl/pattern_tx_serializer.sv
// Repeating MSB-first pattern serializer with gaps and done pulse; PATTERN_TX_PARITY_EN appends a parity beat.
// Latency: first beat one cycle after an accepted start; done_o one cycle after the final beat.
// Backpressure: ready_i low holds d_o/valid_o; gap cycles count wall time regardless of ready_i.
module pattern_tx_serializer
    import pattern_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [CNT_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             ready_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

`ifdef PATTERN_TX_PARITY_EN
    localparam int BEATS = PAT_W + 1;
`else
    localparam int BEATS = PAT_W;
`endif
    localparam int              BIT_W    = $clog2(BEATS);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(BEATS - 1);

    pat_state_t       state, state_nxt;
    logic [PAT_W-1:0] pat_lat;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             sr_load;
    logic             sr_shift;
    logic             start_ok;
    logic [PAT_W-1:0] load_src;
    logic [BEATS-1:0] sr_dat;

    assign start_ok = start_i && (repeat_i != '0);
    assign load_src = (state == IDLE) ? pattern_i : pat_lat;

    // The parity bit rides as the shift register's LSB, so it follows the data beats.
`ifdef PATTERN_TX_PARITY_EN
    assign sr_dat = {load_src, ^load_src};
`else
    assign sr_dat = load_src;
`endif

    always_comb begin
        state_nxt = state;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (repeat_i != '0) begin
                        state_nxt = SHIFT;
                        sr_load   = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                if (ready_i) begin
                    if (bit_cnt != '0) begin
                        sr_shift = 1'b1;
                    end else if (rep_cnt == CNT_W'(1)) begin
                        state_nxt = DONE;
                        sr_shift  = 1'b1;
                    end else if (gap_lat == '0) begin
                        sr_load = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        sr_shift  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = SHIFT;
                    sr_load   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            pat_lat <= '0;
            rep_cnt <= '0;
            gap_lat <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            valid_o <= (state_nxt == SHIFT);
            busy_o  <= (state_nxt == SHIFT) || (state_nxt == GAP);
            done_o  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        pat_lat <= pattern_i;
                        rep_cnt <= repeat_i;
                        gap_lat <= gap_i;
                        bit_cnt <= LAST_IDX;
                    end
                end
                SHIFT: begin
                    if (ready_i) begin
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else begin
                            bit_cnt <= LAST_IDX;
                            rep_cnt <= rep_cnt - 1'b1;
                            gap_cnt <= gap_lat;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    pattern_shift_reg #(
        .PAT_W(BEATS)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (sr_load),
        .shift_en(sr_shift),
        .load_dat(sr_dat),
        .msb     (d_o)
    );

endmodule

// File: doc/pattern_tx_serializer.md
Name: pattern_tx_serializer

Overview:
Serial stimulus transmitter for the pattern-detector interface. It loads a runtime-programmable PAT_W-bit pattern, shifts it out MSB-first on d_o/valid_o, repeats it a programmable number of times with idle gaps between repeats, and pulses done_o at the end. It drives d_i/valid_i of a downstream detector and adds a ready_i backpressure handshake.

Parameters:
PAT_W, 5, pattern width in bits
CNT_W, 8, width of the repeat count
GAP_W, 4, width of the inter-pattern gap count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (rst==0 resets on the clk edge)
start_i  input  1  start request, sampled only in IDLE
pattern_i  input  PAT_W  pattern to send, latched on accepted start
repeat_i  input  CNT_W  number of pattern repeats, latched on start
gap_i  input  GAP_W  idle cycles between repeats, latched on start
ready_i  input  1  downstream accepts the current bit
d_o  output  1  serial data bit
valid_o  output  1  d_o is a valid beat
busy_o  output  1  high in SHIFT and GAP
done_o  output  1  one-cycle pulse when the sequence completes

Behaviour:
- All outputs are registered. Reset values: d_o=0, valid_o=0, busy_o=0, done_o=0. State=IDLE. All counters are 0.
- Reset mid-operation: on the next edge with rst==0, the block returns to IDLE with reset output values. Any partial pattern is discarded.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start_i=1 and repeat_i!=0: latch pattern_i/repeat_i/gap_i, go to SHIFT. valid_o=1 and d_o=pattern[PAT_W-1] in the next cycle, so latency from start to the first beat is 1 cycle.
  - start_i=1 and repeat_i==0: go to DONE with no beats.
- SHIFT:
  - A beat transfers on valid_o && ready_i.
  - While ready_i=0, d_o and valid_o hold stable.
  - Bits go out MSB-first. bit_cnt runs from PAT_W-1 down to 0.
  - After the last bit transfers: decrement rep_cnt. If rep_cnt becomes 0, go to DONE. Otherwise go to GAP, or reload and stay in SHIFT if gap==0, giving back-to-back patterns with no bubble.
- GAP:
  - valid_o=0. Counts gap cycles of wall time, independent of ready_i.
  - Then returns to SHIFT with the pattern reloaded.
  - There is no gap after the final repeat.
- DONE: done_o=1 for exactly one cycle, busy_o=0, valid_o=0, then IDLE.
- start_i is ignored in SHIFT, GAP and DONE. Inputs changing after start have no effect until the next start.
- repeat_i at max value (2^CNT_W-1) must complete without counter wrap.

Optional Feature:
- Macro PATTERN_TX_PARITY_EN.
- Defined: after each PAT_W data bits, one extra beat carries even parity (XOR of the pattern bits), with the same ready_i handshake. Each repeat is then PAT_W+1 beats.
- Undefined: no parity beat; each repeat is exactly PAT_W beats.

Decomposition:
- Shared package pattern_pkg: FSM state enum (IDLE/SHIFT/GAP/DONE, 2-bit encoding) and default width constants PAT_W_DEF=5, CNT_W_DEF=8, GAP_W_DEF=4.
- One sub-module, pattern_shift_reg: parallel load, shift-on-enable, MSB output, PAT_W parameter.
- The FSM and counters stay in the top module.

Test Plan:
- pattern=10110, repeat=2, gap=3, ready=1, start at cycle 0 -> valid_o=1 cycles 1-5 with d_o=1,0,1,1,0; valid_o=0 cycles 6-8; same bits cycles 9-13; done_o=1 at cycle 14 only.
- pattern=11001, repeat=1, ready held 0 for cycles 2-4 -> d_o=1 is held cycles 2-4; the sequence still delivers exactly 1,1,0,0,1 and done_o fires 1 cycle after the last accepted beat.
- repeat=3, gap=0, pattern=10000 -> 15 consecutive valid beats (10000 repeated three times), no valid_o bubble.
- repeat=0 with start -> no valid_o beats; done_o=1 in the cycle after start.
- rst=0 driven during the 3rd bit of the 2nd repeat -> next cycle all outputs 0 and the FSM is in IDLE; a new start then sends the full new pattern from its MSB.
- With PATTERN_TX_PARITY_EN, pattern=10110, repeat=1, ready=1 -> 6 beats 1,0,1,1,0,1, then done_o.
